ov5640_pix_pack: RTL and testbench

OV5640_PIX_PACK -- requirements
Module: ov5640_pix_pack

---
 rtl/ov5640_pix_pack.sv | 150 +++++++++++++++
 tb/tb_ov5640_pix_pack.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov5640_pix_pack.sv
// OV5640 RGB888 -> RGB565 pixel packer: four pixels per 64-bit write word, frame/line tracking.
// Optional statistics (frame counter, line-length error) are built when PIX_PACK_STAT_EN is defined.
module ov5640_pix_pack #(
  parameter int H_ACT = 1024,
  parameter int V_ACT = 768
) (
  input  logic        ov5640_pclk,
  input  logic        s_rst,
  input  logic        in_ce,
  input  logic        in_vsync,
  input  logic        in_href,
  input  logic [23:0] in_data,
  input  logic        wr_full,
  output logic        wr_en,
  output logic [63:0] wr_data,
  output logic        wr_sof,
  output logic        frame_done,
  output logic        overflow,
  output logic [15:0] frame_cnt,
  output logic        err_line_len
);

  typedef enum logic {ST_UNSYNC, ST_SYNC} state_t;

  localparam logic [10:0] LP_V_ACT = 11'(V_ACT);

  state_t      r_state;
  logic        r_vsync_d;
  logic        r_href_d;
  logic [1:0]  r_lane;
  logic [63:0] r_word;
  logic [11:0] r_pix_cnt;
  logic [10:0] r_line_cnt;
  logic        r_emit;
  logic [63:0] r_out_data;
  logic        r_sof_arm;
  logic        r_done_seen;
  logic        r_frame_done;
  logic        r_overflow;

  logic        w_vs_rise;
  logic        w_href_fall;
  logic        w_frame_full;
  logic        w_accept;
  logic [15:0] w_pix;
  logic [63:0] w_word_next;
  logic        w_unused_pad;

  assign w_vs_rise    = in_vsync & ~r_vsync_d;
  assign w_href_fall  = ~in_href & r_href_d;
  assign w_frame_full = (r_line_cnt == LP_V_ACT);
  assign w_accept     = in_ce & in_href & ~in_vsync & (r_state == ST_SYNC) & ~w_frame_full;
  assign w_pix        = {in_data[23:19], in_data[15:10], in_data[7:3]};
  assign w_unused_pad = ^{in_data[18:16], in_data[9:8], in_data[2:0]};

  always_comb begin
    w_word_next = r_word;
    w_word_next[{r_lane, 4'b0000} +: 16] = w_pix;
  end

  // The FIFO full flag gates the strobe in the very cycle the word is presented.
  assign wr_en      = r_emit & ~wr_full;
  assign wr_sof     = wr_en & r_sof_arm;
  assign wr_data    = r_out_data;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

  always_ff @(posedge ov5640_pclk or posedge s_rst) begin
    if (s_rst) begin
      r_state      <= ST_UNSYNC;
      r_vsync_d    <= 1'b0;
      r_href_d     <= 1'b0;
      r_lane       <= 2'd0;
      r_word       <= '0;
      r_pix_cnt    <= '0;
      r_line_cnt   <= '0;
      r_emit       <= 1'b0;
      r_out_data   <= '0;
      r_sof_arm    <= 1'b0;
      r_done_seen  <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_vsync_d    <= in_vsync;
      r_href_d     <= in_href;
      r_emit       <= 1'b0;
      r_frame_done <= w_frame_full & ~r_done_seen;
      r_done_seen  <= w_vs_rise ? 1'b0 : (r_done_seen | w_frame_full);
      if (r_emit) begin
        r_overflow <= r_overflow | wr_full;
        if (!wr_full) r_sof_arm <= 1'b0;
      end
      // A new frame drops any half-built word and restarts all position tracking.
      if (w_vs_rise) begin
        r_state    <= ST_SYNC;
        r_lane     <= 2'd0;
        r_word     <= '0;
        r_pix_cnt  <= '0;
        r_line_cnt <= '0;
        r_sof_arm  <= 1'b1;
      end else if (w_accept) begin
        r_pix_cnt <= r_pix_cnt + 12'd1;
        if (r_lane == 2'd3) begin
          r_emit     <= 1'b1;
          r_out_data <= w_word_next;
          r_word     <= '0;
          r_lane     <= 2'd0;
        end else begin
          r_word <= w_word_next;
          r_lane <= r_lane + 2'd1;
        end
      end else if (w_href_fall) begin
        r_pix_cnt <= '0;
        if (r_lane != 2'd0) begin
          r_emit     <= 1'b1;
          r_out_data <= r_word;
          r_word     <= '0;
          r_lane     <= 2'd0;
        end
        if (r_pix_cnt != 12'd0) r_line_cnt <= r_line_cnt + 11'd1;
      end
    end
  end

`ifdef PIX_PACK_STAT_EN
  localparam logic [11:0] LP_H_ACT = 12'(H_ACT);

  logic [15:0] r_frame_cnt;
  logic        r_err_line;

  always_ff @(posedge ov5640_pclk or posedge s_rst) begin
    if (s_rst) begin
      r_frame_cnt <= '0;
      r_err_line  <= 1'b0;
    end else begin
      if (w_frame_full && !r_done_seen) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_href_fall && (r_pix_cnt != 12'd0) && (r_pix_cnt != LP_H_ACT)) r_err_line <= 1'b1;
    end
  end

  assign frame_cnt    = r_frame_cnt;
  assign err_line_len = r_err_line;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^12'(H_ACT);
  assign frame_cnt    = 16'd0;
  assign err_line_len = 1'b0;
`endif

endmodule

// File: tb/tb_ov5640_pix_pack.sv
// Directed self-checking bench for ov5640_pix_pack (H_ACT=8, V_ACT=2).
module tb_ov5640_pix_pack;

  typedef struct {
    int          cyc;
    logic [63:0] d;
    logic        sof;
  } ev_t;

  logic        clk;
  logic        s_rst;
  logic        in_ce;
  logic        in_vsync;
  logic        in_href;
  logic [23:0] in_data;
  logic        wr_full;
  logic        wr_en;
  logic [63:0] wr_data;
  logic        wr_sof;
  logic        frame_done;
  logic        overflow;
  logic [15:0] frame_cnt;
  logic        err_line_len;

  int   errs;
  int   checks;
  int   cyc;
  int   fd_cnt;
  int   acc_cyc [16];
  int   fall_cyc;
  ev_t  q[$];
  ev_t  ev_tmp;

  ov5640_pix_pack #(.H_ACT(8), .V_ACT(2)) dut (
    .ov5640_pclk (clk),
    .s_rst       (s_rst),
    .in_ce       (in_ce),
    .in_vsync    (in_vsync),
    .in_href     (in_href),
    .in_data     (in_data),
    .wr_full     (wr_full),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_sof      (wr_sof),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .frame_cnt   (frame_cnt),
    .err_line_len(err_line_len)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      ev_tmp.cyc = cyc;
      ev_tmp.d   = wr_data;
      ev_tmp.sof = wr_sof;
      q.push_back(ev_tmp);
    end
    if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    s_rst = 1'b1; in_ce = 1'b0; in_vsync = 1'b0; in_href = 1'b0; in_data = '0; wr_full = 1'b0;
    idle(3);
    s_rst = 1'b0;
    idle(2);
  endtask

  task automatic vsync_pulse();
    in_vsync = 1'b1;
    idle(2);
    in_vsync = 1'b0;
    idle(2);
  endtask

  function automatic logic [23:0] pixdata(input int mode, input int k);
    if (mode == 0) return 24'hF8FC00 + 24'(k);
    return {5'(k), 3'b111, 6'(k), 2'b11, 5'(k), 3'b101};
  endfunction

  task automatic send_line(input int n, input int mode, input int base, input int full_lo, input int full_hi);
    for (int i = 0; i < n; i++) begin
      in_href = 1'b1; in_ce = 1'b1; in_data = pixdata(mode, base + i);
      wr_full = (i >= full_lo && i <= full_hi);
      acc_cyc[i] = cyc;
      tick();
    end
    in_href = 1'b0; in_ce = 1'b0; wr_full = 1'b0;
    fall_cyc = cyc;
    tick();
    idle(3);
  endtask

  task automatic test_reset();
    s_rst = 1'b1; in_ce = 1'b1; in_vsync = 1'b1; in_href = 1'b1; in_data = 24'hFFFFFF; wr_full = 1'b0;
    idle(2);
    in_vsync = 1'b0;
    idle(2);
    checks++; if (wr_en !== 1'b0) begin errs++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
    checks++; if (wr_data !== 64'd0) begin errs++; $display("FAIL rst_wr_data got=%h exp=0", wr_data); end
    checks++; if (wr_sof !== 1'b0) begin errs++; $display("FAIL rst_wr_sof got=%b exp=0", wr_sof); end
    checks++; if (frame_done !== 1'b0) begin errs++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
    checks++; if (overflow !== 1'b0) begin errs++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    checks++; if (frame_cnt !== 16'd0) begin errs++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt); end
    checks++; if (err_line_len !== 1'b0) begin errs++; $display("FAIL rst_err_line got=%b exp=0", err_line_len); end
    in_ce = 1'b0; in_href = 1'b0; in_data = '0;
    s_rst = 1'b0;
    checks++; if (wr_en !== 1'b0 || wr_sof !== 1'b0) begin errs++; $display("FAIL rel_wr_en got=%b/%b exp=0/0", wr_en, wr_sof); end
    checks++; if (wr_data !== 64'd0 || overflow !== 1'b0) begin errs++; $display("FAIL rel_outputs data=%h ovf=%b exp=0", wr_data, overflow); end
    idle(2);
  endtask

  task automatic test_basic();
    do_reset();
    vsync_pulse();
    q.delete();
    send_line(8, 0, 0, -1, -1);
    checks++; if (q.size() != 2) begin errs++; $display("FAIL basic_count got=%0d exp=2", q.size()); end
    if (q.size() == 2) begin
      checks++; if (q[0].d !== 64'hFFE0_FFE0_FFE0_FFE0) begin errs++; $display("FAIL basic_w0 got=%h exp=ffe0ffe0ffe0ffe0", q[0].d); end
      checks++; if (q[0].sof !== 1'b1) begin errs++; $display("FAIL basic_sof0 got=%b exp=1", q[0].sof); end
      checks++; if (q[0].cyc != acc_cyc[3] + 1) begin errs++; $display("FAIL basic_lat0 got=%0d exp=%0d", q[0].cyc, acc_cyc[3] + 1); end
      checks++; if (q[1].d !== 64'hFFE0_FFE0_FFE0_FFE0) begin errs++; $display("FAIL basic_w1 got=%h exp=ffe0ffe0ffe0ffe0", q[1].d); end
      checks++; if (q[1].sof !== 1'b0) begin errs++; $display("FAIL basic_sof1 got=%b exp=0", q[1].sof); end
      checks++; if (q[1].cyc != acc_cyc[7] + 1) begin errs++; $display("FAIL basic_lat1 got=%0d exp=%0d", q[1].cyc, acc_cyc[7] + 1); end
    end
  endtask

  task automatic test_unsynced();
    do_reset();
    q.delete();
    send_line(8, 1, 1, -1, -1);
    checks++; if (q.size() != 0) begin errs++; $display("FAIL unsync_count got=%0d exp=0", q.size()); end
    vsync_pulse();
    q.delete();
    send_line(8, 1, 1, -1, -1);
    checks++; if (q.size() != 2) begin errs++; $display("FAIL sync_count got=%0d exp=2", q.size()); end
    if (q.size() == 2) begin
      checks++; if (q[0].d !== 64'h2084_1863_1042_0821) begin errs++; $display("FAIL order_w0 got=%h exp=2084186310420821", q[0].d); end
      checks++; if (q[0].sof !== 1'b1) begin errs++; $display("FAIL order_sof got=%b exp=1", q[0].sof); end
      checks++; if (q[1].d !== 64'h4108_38E7_30C6_28A5) begin errs++; $display("FAIL order_w1 got=%h exp=410838e730c628a5", q[1].d); end
    end
  endtask

  task automatic test_partial();
    do_reset();
    vsync_pulse();
    q.delete();
    send_line(6, 1, 1, -1, -1);
    checks++; if (q.size() != 2) begin errs++; $display("FAIL part_count got=%0d exp=2", q.size()); end
    if (q.size() == 2) begin
      checks++; if (q[0].d !== 64'h2084_1863_1042_0821) begin errs++; $display("FAIL part_w0 got=%h exp=2084186310420821", q[0].d); end
      checks++; if (q[1].d !== 64'h0000_0000_30C6_28A5) begin errs++; $display("FAIL part_w1 got=%h exp=0000000030c628a5", q[1].d); end
      checks++; if (q[1].cyc != fall_cyc + 1) begin errs++; $display("FAIL part_lat got=%0d exp=%0d", q[1].cyc, fall_cyc + 1); end
    end
    q.delete();
    send_line(4, 1, 1, -1, -1);
    checks++; if (q.size() != 1) begin errs++; $display("FAIL exact_count got=%0d exp=1", q.size()); end
  endtask

  task automatic test_overflow();
    do_reset();
    vsync_pulse();
    q.delete();
    send_line(12, 1, 1, 5, 8);
    checks++; if (q.size() != 2) begin errs++; $display("FAIL ovf_count got=%0d exp=2", q.size()); end
    if (q.size() == 2) begin
      checks++; if (q[0].d !== 64'h2084_1863_1042_0821) begin errs++; $display("FAIL ovf_w0 got=%h exp=2084186310420821", q[0].d); end
      checks++; if (q[1].d !== 64'h618C_596B_514A_4929) begin errs++; $display("FAIL ovf_w2 got=%h exp=618c596b514a4929", q[1].d); end
      checks++; if (q[1].cyc != acc_cyc[11] + 1) begin errs++; $display("FAIL ovf_lat got=%0d exp=%0d", q[1].cyc, acc_cyc[11] + 1); end
    end
    checks++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    vsync_pulse();
    checks++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_frames();
    logic [15:0] exp_cnt;
    logic        exp_err;
`ifdef PIX_PACK_STAT_EN
    exp_cnt = 16'd3; exp_err = 1'b1;
`else
    exp_cnt = 16'd0; exp_err = 1'b0;
`endif
    do_reset();
    fd_cnt = 0;
    q.delete();
    for (int f = 0; f < 3; f++) begin
      vsync_pulse();
      send_line(8, 0, 0, -1, -1);
      send_line(8, 0, 0, -1, -1);
      if (f == 1) send_line(8, 0, 0, -1, -1);
    end
    checks++; if (fd_cnt != 3) begin errs++; $display("FAIL frames_done got=%0d exp=3", fd_cnt); end
    checks++; if (q.size() != 12) begin errs++; $display("FAIL frames_words got=%0d exp=12", q.size()); end
    checks++; if (frame_cnt !== exp_cnt) begin errs++; $display("FAIL frames_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    checks++; if (err_line_len !== 1'b0) begin errs++; $display("FAIL frames_err got=%b exp=0", err_line_len); end
    vsync_pulse();
    q.delete();
    send_line(7, 0, 0, -1, -1);
    checks++; if (err_line_len !== exp_err) begin errs++; $display("FAIL short_err got=%b exp=%b", err_line_len, exp_err); end
    checks++; if (q.size() != 2) begin errs++; $display("FAIL short_count got=%0d exp=2", q.size()); end
    if (q.size() == 2) begin
      checks++; if (q[1].d !== 64'h0000_FFE0_FFE0_FFE0) begin errs++; $display("FAIL short_w1 got=%h exp=0000ffe0ffe0ffe0", q[1].d); end
    end
  endtask

  task automatic test_reset_midline();
    do_reset();
    vsync_pulse();
    q.delete();
    for (int i = 0; i < 2; i++) begin
      in_href = 1'b1; in_ce = 1'b1; in_data = pixdata(1, i + 1);
      tick();
    end
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_data = pixdata(1, i + 3);
      tick();
    end
    in_href = 1'b0; in_ce = 1'b0;
    idle(4);
    checks++; if (q.size() != 0) begin errs++; $display("FAIL midrst_count got=%0d exp=0", q.size()); end
    send_line(4, 1, 1, -1, -1);
    checks++; if (q.size() != 0) begin errs++; $display("FAIL midrst_unsync got=%0d exp=0", q.size()); end
    vsync_pulse();
    send_line(4, 1, 1, -1, -1);
    checks++; if (q.size() != 1) begin errs++; $display("FAIL midrst_resume got=%0d exp=1", q.size()); end
    if (q.size() == 1) begin
      checks++; if (q[0].d !== 64'h2084_1863_1042_0821 || q[0].sof !== 1'b1) begin errs++; $display("FAIL midrst_word got=%h/%b exp=2084186310420821/1", q[0].d, q[0].sof); end
    end
  endtask

  task automatic test_ce_gap();
    do_reset();
    vsync_pulse();
    q.delete();
    for (int i = 0; i < 8; i++) begin
      in_href = 1'b1; in_ce = i[0]; in_data = pixdata(1, i);
      tick();
    end
    in_href = 1'b0; in_ce = 1'b0;
    idle(4);
    checks++; if (q.size() != 1) begin errs++; $display("FAIL cegap_count got=%0d exp=1", q.size()); end
    if (q.size() == 1) begin
      checks++; if (q[0].d !== 64'h38E7_28A5_1863_0821) begin errs++; $display("FAIL cegap_word got=%h exp=38e728a518630821", q[0].d); end
    end
  endtask

  initial begin
    errs = 0; checks = 0; cyc = 0; fd_cnt = 0; fall_cyc = 0;
    s_rst = 1'b1; in_ce = 1'b0; in_vsync = 1'b0; in_href = 1'b0; in_data = '0; wr_full = 1'b0;
    test_reset();
    test_basic();
    test_unsynced();
    test_partial();
    test_overflow();
    test_frames();
    test_reset_midline();
    test_ce_gap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
